// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//   Iterative unsigned restoring divider. Divides a 2*WIDTH-bit dividend by a
//   WIDTH-bit divisor, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
//   One quotient bit is resolved per clock in CALC. A zero divisor, or a
//   quotient too wide for WIDTH bits, is flagged straight away without
//   iterating. A sideband control word is carried alongside each operation.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   dividend, divisor     unsigned operands, captured at accept
//   control_signals_in    sideband captured at accept
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   quotient, remainder   results, held stable while out_valid=1
//   div_by_zero, overflow status flags qualified by out_valid
//   control_signals_out   sideband of the operation being presented
//   dbg_state             current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. A source holds valid and its data steady until that edge; the receiver's
// ready never depends combinationally on valid. Here both ready/valid outputs
// are pure decodes of the registered state.
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int WIDTH                 = 8,
  parameter int CONTROL_SIGNALS_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2*WIDTH-1:0]               dividend,
  input  logic [WIDTH-1:0]                 divisor,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0] control_signals_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 quotient,
  output logic [WIDTH-1:0]                 remainder,
  output logic                             div_by_zero,
  output logic                             overflow,
  output logic [CONTROL_SIGNALS_WIDTH-1:0] control_signals_out,
  output logic [1:0]                       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [WIDTH-1:0]         r_p;    // partial remainder, always < r_d in CALC
  logic [WIDTH-1:0]         r_q;    // dividend low half shifting out, quotient shifting in
  logic [WIDTH-1:0]         r_d;    // latched divisor
  logic [CNT_W-1:0]         r_cnt;  // steps completed so far

  logic [WIDTH-1:0]         w_in_p;
  logic [WIDTH-1:0]         w_in_q;
  logic [WIDTH:0]           w_t;
  logic [WIDTH:0]           w_diff;
  logic                     w_ge;
  logic [WIDTH-1:0]         w_p_next;
  logic [WIDTH-1:0]         w_q_next;

  assign w_in_p = dividend[2*WIDTH-1:WIDTH];
  assign w_in_q = dividend[WIDTH-1:0];

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. Because r_p < r_d, the
  // (WIDTH+1)-bit trial value minus r_d always fits back into WIDTH bits.
  assign w_t      = {r_p, r_q[WIDTH-1]};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_diff   = w_t - {1'b0, r_d};
  assign w_p_next = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_next = {r_q[WIDTH-2:0], w_ge};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= S_IDLE;
      r_p                 <= '0;
      r_q                 <= '0;
      r_d                 <= '0;
      r_cnt               <= '0;
      quotient            <= '0;
      remainder           <= '0;
      div_by_zero         <= 1'b0;
      overflow            <= 1'b0;
      control_signals_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_d                 <= divisor;
            r_p                 <= w_in_p;
            r_q                 <= w_in_q;
            r_cnt               <= '0;
            control_signals_out <= control_signals_in;
            if (divisor == '0) begin
              r_state     <= S_DONE;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= '1;
              remainder   <= '0;
            end else if (w_in_p >= divisor) begin
              // High half already >= divisor: quotient needs more than WIDTH bits.
              r_state     <= S_DONE;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_p   <= w_p_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_state     <= S_DONE;
            quotient    <= w_q_next;
            remainder   <= w_p_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
